// File: rtl/limb_pkg.sv
// Shared state encoding and default parameter values for the LIMB-to-Wishbone bridge.
package limb_pkg;

  localparam int DEF_ADDR_BYTES = 5;
  localparam int DEF_DATA_BYTES = 4;
  localparam int DEF_WB_ADR_W   = 36;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA_W   = 3'd2,
    WB_WRITE = 3'd3,
    WB_READ  = 3'd4,
    DATA_R   = 3'd5
  } limb_state_e;

endpackage

// File: rtl/limb_strobe_sync.sv
// Two-flop synchroniser for the LIMB control pins plus a rising-edge detector that
// yields a registered one-cycle byte event, with start/nrd delayed to line up with it.
module limb_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic limb_clk,
  input  logic limb_start,
  input  logic limb_nrd,
  output logic byte_event,
  output logic start,
  output logic nrd
);

  logic [1:0] clk_sync;
  logic [1:0] start_sync;
  logic [1:0] nrd_sync;
  logic       clk_prev;

  // synchroniser chains and registered edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync   <= 2'b00;
      start_sync <= 2'b00;
      nrd_sync   <= 2'b00;
      clk_prev   <= 1'b0;
      byte_event <= 1'b0;
      start      <= 1'b0;
      nrd        <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], limb_clk};
      start_sync <= {start_sync[0], limb_start};
      nrd_sync   <= {nrd_sync[0], limb_nrd};
      clk_prev   <= clk_sync[1];
      byte_event <= clk_sync[1] & ~clk_prev;
      start      <= start_sync[1];
      nrd        <= nrd_sync[1];
    end
  end

endmodule

// File: rtl/limb_wb_bridge.sv
// LIMB byte-parallel host port to Wishbone classic master bridge with address
// autoincrement, per-cycle ack timeout and sticky error flag.
module limb_wb_bridge
  import limb_pkg::*;
#(
  parameter int ADDR_BYTES = DEF_ADDR_BYTES,
  parameter int DATA_BYTES = DEF_DATA_BYTES,
  parameter int WB_ADR_W   = DEF_WB_ADR_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              limb_d_in,
  output logic [7:0]              limb_d_out,
  output logic                    limb_d_oe,
  input  logic                    limb_clk,
  input  logic                    limb_nrd,
  input  logic                    limb_start,
  output logic                    limb_nwait,
  output logic                    limb_err,
  output logic [WB_ADR_W-1:0]     wb_adr_o,
  output logic [8*DATA_BYTES-1:0] wb_dat_o,
  input  logic [8*DATA_BYTES-1:0] wb_dat_i,
  output logic [DATA_BYTES-1:0]   wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i
);

  localparam logic [2:0]  ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BYTES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  limb_state_e             state;
  limb_state_e             state_nxt;
  logic                    byte_event;
  logic                    ev_start;
  logic                    ev_nrd;
  logic                    restart;
  logic                    in_wb;
  logic                    tmo_hit;
  logic                    dir_wr;
  logic [2:0]              idx;
  logic [15:0]             tmo_cnt;
  logic [WB_ADR_W-1:0]     addr;
  logic [8*DATA_BYTES-1:0] wdata;
  logic [8*DATA_BYTES-1:0] rdata;

  // Address bits beyond WB_ADR_W simply have no bit to land in.
  function automatic logic [WB_ADR_W-1:0] put_addr_byte(input logic [WB_ADR_W-1:0] cur,
                                                         input logic [7:0] b,
                                                         input logic [2:0] k);
    logic [WB_ADR_W-1:0] r;
    r = cur;
    for (int i = 0; i < WB_ADR_W; i++) begin
      if ((i / 8) == int'(k)) r[i] = b[i % 8];
    end
    return r;
  endfunction

  limb_strobe_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .limb_clk   (limb_clk),
    .limb_start (limb_start),
    .limb_nrd   (limb_nrd),
    .byte_event (byte_event),
    .start      (ev_start),
    .nrd        (ev_nrd)
  );

  assign restart  = byte_event & ev_start;
  assign in_wb    = (state == WB_WRITE) || (state == WB_READ);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign wb_adr_o = addr;
  assign wb_dat_o = wdata;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; a start byte overrides everything, ack beats timeout
  always_comb begin
    state_nxt = state;
    if (restart) begin
      if (ADDR_BYTES == 1) state_nxt = ev_nrd ? DATA_W : WB_READ;
      else                 state_nxt = ADDR;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        ADDR:     if (byte_event && idx == ADDR_LAST) state_nxt = dir_wr ? DATA_W : WB_READ;
                  else state_nxt = ADDR;
        DATA_W:   if (byte_event && idx == DATA_LAST) state_nxt = WB_WRITE;
                  else state_nxt = DATA_W;
        WB_WRITE: if (wb_ack_i) state_nxt = DATA_W;
                  else if (tmo_hit) state_nxt = IDLE;
                  else state_nxt = WB_WRITE;
        WB_READ:  if (wb_ack_i) state_nxt = DATA_R;
                  else if (tmo_hit) state_nxt = IDLE;
                  else state_nxt = WB_READ;
        DATA_R:   if (byte_event && idx == DATA_LAST) state_nxt = WB_READ;
                  else state_nxt = DATA_R;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_sel_o   = '0;
    limb_nwait = 1'b1;
    limb_d_oe  = 1'b0;
    limb_d_out = 8'h00;
    case (state)
      WB_WRITE: begin
        wb_cyc_o   = 1'b1;
        wb_stb_o   = 1'b1;
        wb_we_o    = 1'b1;
        wb_sel_o   = '1;
        limb_nwait = 1'b0;
      end
      WB_READ: begin
        wb_cyc_o   = 1'b1;
        wb_stb_o   = 1'b1;
        wb_sel_o   = '1;
        limb_nwait = 1'b0;
      end
      DATA_R: begin
        limb_d_oe = 1'b1;
        for (int k = 0; k < DATA_BYTES; k++) begin
          if (idx == 3'(k)) limb_d_out = rdata[8*k +: 8];
        end
      end
      default: limb_d_oe = 1'b0;
    endcase
  end

  // datapath: byte collection, ack capture, autoincrement, timeout and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      idx      <= 3'd0;
      dir_wr   <= 1'b0;
      tmo_cnt  <= 16'd0;
      limb_err <= 1'b0;
    end else begin
      if (restart || !in_wb || wb_ack_i || tmo_hit) tmo_cnt <= 16'd0;
      else                                          tmo_cnt <= tmo_cnt + 16'd1;

      if (restart) begin
        addr     <= put_addr_byte('0, limb_d_in, 3'd0);
        idx      <= (ADDR_BYTES == 1) ? 3'd0 : 3'd1;
        dir_wr   <= ev_nrd;
        limb_err <= 1'b0;
      end else begin
        case (state)
          ADDR: if (byte_event) begin
            addr <= put_addr_byte(addr, limb_d_in, idx);
            idx  <= (idx == ADDR_LAST) ? 3'd0 : idx + 3'd1;
          end
          DATA_W: if (byte_event) begin
            for (int k = 0; k < DATA_BYTES; k++) begin
              if (idx == 3'(k)) wdata[8*k +: 8] <= limb_d_in;
            end
            idx <= (idx == DATA_LAST) ? 3'd0 : idx + 3'd1;
          end
          WB_WRITE, WB_READ: begin
            if (wb_ack_i) begin
              addr <= addr + WB_ADR_W'(1);
              if (state == WB_READ) rdata <= wb_dat_i;
            end else if (tmo_hit) begin
              limb_err <= 1'b1;
            end
          end
          DATA_R: if (byte_event) idx <= (idx == DATA_LAST) ? 3'd0 : idx + 3'd1;
          default: idx <= idx;
        endcase
      end
    end
  end

endmodule
